// File: rtl/radio_ook_trx.sv
// rtl/radio_ook_trx.sv - OOK half-duplex radio transceiver with carrier sense; RADIO_COLL_DET_EN adds collision detect
module radio_ook_trx #(
    parameter int BIT_CYCLES = 16,
    parameter int GAP_BITS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       ant_o,
    output logic       ant_oe,
    input  logic       ant_i
`ifdef RADIO_COLL_DET_EN
    ,
    output logic       tx_coll
`endif
);

    localparam logic [7:0]  BC_LAST  = 8'(BIT_CYCLES - 1);
    localparam logic [7:0]  BC_MID   = 8'(BIT_CYCLES / 2);
    localparam int          GAP_LEN  = (GAP_BITS * BIT_CYCLES > 0) ? GAP_BITS * BIT_CYCLES : 1;
    localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_WAIT_CS, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  cs_cnt_q, cs_cnt_d;
    logic        ready_en_q, ready_en_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [7:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_wait_q, rx_wait_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ferr_q, rx_ferr_d;

    logic on_air, cur_bit, ant_s, bit_end, mid_bit, coll, xfer, rise;

    assign ant_s    = sync2_q;
    assign rise     = sync2_q && !prev_q;
    assign on_air   = (tx_state_q == TX_START) || (tx_state_q == TX_DATA) || (tx_state_q == TX_STOP);
    assign cur_bit  = (tx_state_q == TX_START) ||
                      ((tx_state_q == TX_DATA) && tx_byte_q[tx_bit_q]);
    assign bit_end  = (tx_cnt_q == {8'h00, BC_LAST});
    assign mid_bit  = (tx_cnt_q == {8'h00, BC_MID});
    assign tx_ready = (tx_state_q == TX_IDLE) && ready_en_q;
    assign xfer     = tx_valid && tx_ready;
    assign tx_busy  = (tx_state_q != TX_IDLE) || xfer;
    assign ant_oe   = on_air;
    assign ant_o    = on_air && cur_bit;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;

    // A collision is the peer carrier seen while we drive a 0, judged at mid-bit only
`ifdef RADIO_COLL_DET_EN
    assign coll    = on_air && !cur_bit && ant_s && mid_bit;
    assign tx_coll = coll;
`else
    assign coll    = 1'b0;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        cs_cnt_d   = cs_cnt_q;
        ready_en_d = 1'b1;
        sync1_d    = ant_i;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (xfer) begin
                    tx_byte_d  = tx_data;
                    cs_cnt_d   = 8'd0;
                    tx_state_d = TX_WAIT_CS;
                end
            end
            TX_WAIT_CS: begin
                if (ant_s) begin
                    cs_cnt_d = 8'd0;
                end else if (cs_cnt_q == BC_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = TX_START;
                end else begin
                    cs_cnt_d = cs_cnt_q + 8'd1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (coll) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = TX_GAP;
                end else if (bit_end) begin
                    tx_cnt_d = 16'd0;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (coll || bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = TX_GAP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_GAP: begin
                if (tx_cnt_q == GAP_LAST) tx_state_d = TX_IDLE;
                else                      tx_cnt_d   = tx_cnt_q + 16'd1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Receiver is held idle while we are on air so our own frame is never decoded
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_wait_d  = rx_wait_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        if (on_air) begin
            rx_state_d = RX_IDLE;
            rx_wait_d  = 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rise) begin
                        rx_cnt_d   = 8'd1;
                        rx_state_d = RX_START_CHK;
                    end
                end
                RX_START_CHK: begin
                    if ((rx_cnt_q == BC_MID) && !ant_s) begin
                        rx_state_d = RX_IDLE;
                    end else if (rx_cnt_q == BC_LAST) begin
                        rx_cnt_d   = 8'd0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 8'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BC_MID) rx_shift_d[rx_bit_q] = ant_s;
                    if (rx_cnt_q == BC_LAST) begin
                        rx_cnt_d = 8'd0;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 8'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_wait_q) begin
                        if (!ant_s) begin
                            rx_wait_d  = 1'b0;
                            rx_state_d = RX_IDLE;
                        end
                    end else if (rx_cnt_q == BC_MID) begin
                        if (!ant_s) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_ferr_d = 1'b1;
                            rx_wait_d = 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 8'd1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_byte_q  <= 8'h00;
            cs_cnt_q   <= 8'd0;
            ready_en_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 8'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_wait_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            cs_cnt_q   <= cs_cnt_d;
            ready_en_q <= ready_en_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_wait_q  <= rx_wait_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

endmodule

// File: tb/tb_radio_ook_trx.sv
// tb/tb_radio_ook_trx.sv - two transceivers on a wired-OR antenna plus a bench-driven peer line
module tb_radio_ook_trx;
    localparam int BC = 4;
    localparam int GB = 2;
    localparam int GAP_LEN = GB * BC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ext_ant = 1'b0;
    logic [7:0] a_tx_data = 8'h00, b_tx_data = 8'h00;
    logic a_tx_valid = 1'b0, b_tx_valid = 1'b0;
    logic a_ready, a_busy, a_rx_valid, a_rx_ferr, a_o, a_oe;
    logic b_ready, b_busy, b_rx_valid, b_rx_ferr, b_o, b_oe;
    logic [7:0] a_rx_data, b_rx_data;
    logic ant;
`ifdef RADIO_COLL_DET_EN
    logic a_coll, b_coll;
`endif
    int checks = 0;
    int passes = 0;
    logic [7:0] last_b = 8'h00;

    always #5 clk = ~clk;
    assign ant = (a_oe & a_o) | (b_oe & b_o) | ext_ant;

    radio_ook_trx #(.BIT_CYCLES(BC), .GAP_BITS(GB)) u_a (
        .clk(clk), .reset(reset), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_ready),
        .tx_busy(a_busy), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ferr(a_rx_ferr),
        .ant_o(a_o), .ant_oe(a_oe), .ant_i(ant)
`ifdef RADIO_COLL_DET_EN
        , .tx_coll(a_coll)
`endif
    );

    radio_ook_trx #(.BIT_CYCLES(BC), .GAP_BITS(GB)) u_b (
        .clk(clk), .reset(reset), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_ready),
        .tx_busy(b_busy), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ferr(b_rx_ferr),
        .ant_o(b_o), .ant_oe(b_oe), .ant_i(ant)
`ifdef RADIO_COLL_DET_EN
        , .tx_coll(b_coll)
`endif
    );

    // Reference line level k cycles into a frame: start 1, data LSB first, stop 0
    function automatic logic model_level(input logic [7:0] d, input int k);
        int b;
        b = k / BC;
        if (b == 0) return 1'b1;
        if (b <= 8) return d[b-1];
        return 1'b0;
    endfunction

    task automatic do_transfer(input bit from_b, input logic [7:0] d);
        int w;
        w = 0;
        while (!(from_b ? b_ready : a_ready) && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 300) $display("FAIL tx_ready_timeout from_b=%0d waited=%0d required<300", from_b, w);
        else passes++;
        if (from_b) begin b_tx_data = d; b_tx_valid = 1'b1; end
        else        begin a_tx_data = d; a_tx_valid = 1'b1; end
        @(negedge clk);
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({a_ready, a_busy, a_oe, a_o, a_rx_valid, a_rx_ferr} !== 6'b0)
            $display("FAIL reset_outputs got %b required 000000", {a_ready, a_busy, a_oe, a_o, a_rx_valid, a_rx_ferr});
        else passes++;
        checks++;
        if (a_rx_data !== 8'h00) $display("FAIL reset_rx_data got %h required 00", a_rx_data);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b0) $display("FAIL ready_before_edge got %b required 0", a_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL ready_after_release got %b%b required 11", a_ready, b_ready);
        else passes++;
    endtask

    task automatic xmit(input bit from_b, input logic [7:0] d);
        int first_oe, oe_cnt, lvl_err, last_busy, rv_rx, rv_tx, fe;
        logic [7:0] got;
        first_oe = -1; oe_cnt = 0; lvl_err = 0; last_busy = -1; rv_rx = 0; rv_tx = 0; fe = 0; got = 8'hxx;
        do_transfer(from_b, d);
        for (int n = 1; n <= 90; n++) begin
            if (from_b ? b_oe : a_oe) begin
                if (first_oe < 0) first_oe = n;
                oe_cnt++;
                if ((from_b ? b_o : a_o) !== model_level(d, n - first_oe)) lvl_err++;
            end
            if (from_b ? b_busy : a_busy) last_busy = n;
            if (from_b ? a_rx_valid : b_rx_valid) begin rv_rx++; got = from_b ? a_rx_data : b_rx_data; end
            if (from_b ? b_rx_valid : a_rx_valid) rv_tx++;
            if (a_rx_ferr || b_rx_ferr) fe++;
            @(negedge clk);
        end
        checks++;
        if (first_oe !== BC + 1) $display("FAIL frame_start d=%h got %0d required %0d", d, first_oe, BC + 1);
        else passes++;
        checks++;
        if (oe_cnt !== 10 * BC || lvl_err !== 0) $display("FAIL frame_air d=%h oe=%0d bad=%0d required oe=%0d bad=0", d, oe_cnt, lvl_err, 10 * BC);
        else passes++;
        checks++;
        if (last_busy !== 11 * BC + GAP_LEN) $display("FAIL busy_len d=%h got %0d required %0d", d, last_busy, 11 * BC + GAP_LEN);
        else passes++;
        checks++;
        if (rv_rx !== 1 || got !== d) $display("FAIL peer_rx d=%h pulses=%0d data=%h required 1 pulse", d, rv_rx, got);
        else passes++;
        checks++;
        if (rv_tx !== 0 || fe !== 0) $display("FAIL self_rx d=%h pulses=%0d ferr=%0d required 0 0", d, rv_tx, fe);
        else passes++;
        if (!from_b) last_b = d;
    endtask

    task automatic test_frame;
        xmit(0, 8'hA5);
        xmit(0, 8'h3C);
        for (int i = 0; i < 3; i++) xmit(0, 8'($urandom));
        for (int i = 0; i < 2; i++) xmit(1, 8'($urandom));
    endtask

    task automatic test_carrier_sense;
        int oe_high, busy_low, idx;
        oe_high = 0; busy_low = 0; idx = -1;
        ext_ant = 1'b1;
        repeat (10) @(negedge clk);
        do_transfer(0, 8'($urandom));
        for (int n = 0; n < 19; n++) begin
            if (a_oe) oe_high++;
            if (!a_busy) busy_low++;
            @(negedge clk);
        end
        ext_ant = 1'b0;
        for (int n = 0; n < 40 && idx < 0; n++) begin
            if (a_oe) idx = n;
            @(negedge clk);
        end
        checks++;
        if (oe_high !== 0 || busy_low !== 0) $display("FAIL cs_hold oe=%0d busy_low=%0d required 0 0", oe_high, busy_low);
        else passes++;
        checks++;
        if (idx < 5 || idx > 8) $display("FAIL cs_start got %0d cycles after fall required 5..8", idx);
        else passes++;
        repeat (120) @(negedge clk);
    endtask

    task automatic test_ferr;
        logic [7:0] d, prior;
        int av, bv, af, bf, both;
        prior = 8'($urandom);
        xmit(0, prior);
        for (int pass = 0; pass < 2; pass++) begin
            d = 8'($urandom);
            av = 0; bv = 0; af = 0; bf = 0; both = 0;
            for (int n = 0; n < 10 * BC + 46; n++) begin
                if (a_rx_valid) av++;
                if (b_rx_valid) bv++;
                if (a_rx_ferr) af++;
                if (b_rx_ferr) bf++;
                if ((a_rx_valid && a_rx_ferr) || (b_rx_valid && b_rx_ferr)) both++;
                if (n < 9 * BC) ext_ant = model_level(d, n);
                else ext_ant = (pass == 0) && (n < 10 * BC + 6);
                @(negedge clk);
            end
            if (pass == 0) begin
                checks++;
                if (af !== 1 || bf !== 1 || av !== 0 || bv !== 0)
                    $display("FAIL ferr_pulse a_ferr=%0d b_ferr=%0d a_valid=%0d b_valid=%0d required 1 1 0 0", af, bf, av, bv);
                else passes++;
                checks++;
                if (b_rx_data !== prior) $display("FAIL ferr_hold got %h required %h", b_rx_data, prior);
                else passes++;
            end else begin
                checks++;
                if (bv !== 1 || av !== 1 || af !== 0 || bf !== 0 || b_rx_data !== d || a_rx_data !== d)
                    $display("FAIL rx_after_ferr a=%h b=%h av=%0d bv=%0d required %h once", a_rx_data, b_rx_data, av, bv, d);
                else passes++;
                last_b = d;
            end
            checks++;
            if (both !== 0) $display("FAIL valid_ferr_overlap got %0d required 0", both);
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int w, rv;
        w = 0; rv = 0;
        do_transfer(0, 8'($urandom));
        while (!a_oe && w < 50) begin @(negedge clk); w++; end
        repeat (4 * BC + 1) @(negedge clk);
        checks++;
        if (a_oe !== 1'b1) $display("FAIL pre_reset_on_air got %b required 1", a_oe);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_oe, a_o, a_busy, a_ready, b_rx_valid} !== 5'b0)
            $display("FAIL reset_mid got %b required 00000", {a_oe, a_o, a_busy, a_ready, b_rx_valid});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || b_rx_data !== 8'h00)
            $display("FAIL reset_mid_release ready=%b%b rx=%h required 11 00", a_ready, b_ready, b_rx_data);
        else passes++;
        last_b = 8'h00;
        for (int n = 0; n < 60; n++) begin
            if (a_rx_valid || b_rx_valid) rv++;
            @(negedge clk);
        end
        checks++;
        if (rv !== 0) $display("FAIL reset_mid_no_rx got %0d required 0", rv);
        else passes++;
    endtask

`ifdef RADIO_COLL_DET_EN
    task automatic test_collision;
        logic [7:0] d;
        int k, first, c, coll_cnt, last_busy, oe_after;
        d = 8'($urandom);
        k = $urandom_range(0, 7);
        d[k] = 1'b0;
        first = -1; c = -1; coll_cnt = 0; last_busy = -1; oe_after = -1;
        do_transfer(0, d);
        for (int n = 1; n <= 120; n++) begin
            if (a_oe && first < 0) first = n;
            if (a_coll) begin coll_cnt++; if (c < 0) c = n; end
            if (c >= 0 && n == c + 1) begin oe_after = int'(a_oe); ext_ant = 1'b0; end
            if (a_busy) last_busy = n;
            if (first >= 0 && n == first + BC * (1 + k) - 1) ext_ant = 1'b1;
            @(negedge clk);
        end
        ext_ant = 1'b0;
        checks++;
        if (coll_cnt !== 1 || c !== first + BC * (1 + k) + BC / 2)
            $display("FAIL coll_pulse count=%0d at=%0d required 1 at %0d", coll_cnt, c, first + BC * (1 + k) + BC / 2);
        else passes++;
        checks++;
        if (oe_after !== 0) $display("FAIL coll_oe_drop got %0d required 0", oe_after);
        else passes++;
        checks++;
        if (last_busy !== c + GAP_LEN) $display("FAIL coll_gap last_busy=%0d required %0d", last_busy, c + GAP_LEN);
        else passes++;
        repeat (80) @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_frame;
        test_carrier_sense;
        test_ferr;
        test_reset_mid;
`ifdef RADIO_COLL_DET_EN
        test_collision;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/radio_ook_trx.md
RADIO_OOK_TRX -- requirements
Module: radio_ook_trx

Interface
REQ-001 Parameter BIT_CYCLES, default 16; clk cycles per on-air bit, legal range 4..255.
REQ-002 Parameter GAP_BITS, default 2; idle bit-times enforced after every transmitted frame.
REQ-003 Port clk  input  1  system clock; the block uses only this clock.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port tx_data  input  8  byte to transmit.
REQ-006 Port tx_valid  input  1  tx_data is valid.
REQ-007 Port tx_ready  output  1  block accepts tx_data this cycle.
REQ-008 Port tx_busy  output  1  a frame is queued, in flight or in gap.
REQ-009 Port rx_data  output  8  last received byte.
REQ-010 Port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 Port rx_ferr  output  1  one-cycle pulse when a frame is received with a bad stop bit.
REQ-012 Port ant_o  output  1  drive level onto the shared antenna wire.
REQ-013 Port ant_oe  output  1  output enable for ant_o.
REQ-014 Port ant_i  input  1  sensed antenna level, including own and peer transmissions.
REQ-015 Port tx_coll  output  1  one-cycle collision pulse; present only with RADIO_COLL_DET_EN.

Function
REQ-016 Frame format: idle low; start bit 1; 8 data bits LSB first, 1=carrier on; stop bit 0; each bit lasts BIT_CYCLES cycles.
REQ-017 tx_ready is high only in TX state IDLE with no byte held; a transfer occurs when tx_valid and tx_ready are high on the same rising edge.
REQ-018 TX FSM states: IDLE -> WAIT_CS on transfer; WAIT_CS -> START when ant_i has been low for BIT_CYCLES consecutive cycles (carrier sense); START -> DATA -> STOP -> GAP -> IDLE.
REQ-019 ant_oe is high in START, DATA and STOP, and low in all other states; ant_o equals the current bit value while ant_oe is high, else 0.
REQ-020 First START cycle follows the carrier-sense-satisfied cycle by exactly 1 clk; total frame on air is 10*BIT_CYCLES cycles.
REQ-021 GAP lasts GAP_BITS*BIT_CYCLES cycles; tx_busy is high from the transfer cycle until the block returns to IDLE.
REQ-022 RX FSM states: IDLE, START_CHK, DATA, STOP; RX runs only while TX is not in START, DATA or STOP (no self-reception).
REQ-023 RX samples ant_i through a 2-flop synchroniser; the rising edge of the synchronised signal in RX IDLE starts the bit counter.
REQ-024 Sampling occurs at mid-bit (BIT_CYCLES/2, integer division); if the start bit samples 0, RX returns to IDLE silently.
REQ-025 On the stop sample: 0 -> rx_data is loaded and rx_valid pulses; 1 -> rx_data is unchanged, rx_ferr pulses, and RX waits for the synchronised ant_i to go low before IDLE.
REQ-026 rx_valid and rx_ferr are never high together; rx_valid is not gated by any downstream ready, and an unread byte is overwritten.
REQ-027 All bit and cycle counters saturate or reload explicitly and never wrap mid-bit.

Reset
REQ-028 Asserting reset, at any time including mid-frame, forces both FSMs to IDLE within the same cycle (asynchronous).
REQ-029 During reset: tx_ready=0, tx_busy=0, ant_oe=0, ant_o=0, rx_valid=0, rx_ferr=0, tx_coll=0, rx_data=8'h00, synchroniser flops=0.
REQ-030 tx_ready rises on the first clk edge after reset deasserts.

Configuration
REQ-031 Macro RADIO_COLL_DET_EN: when defined, a collision is ant_oe=1, ant_o=0 and synchronised ant_i=1, sampled at mid-bit.
REQ-032 On a collision: tx_coll pulses once, ant_oe drops on the next cycle, the TX FSM goes to GAP, and the byte is discarded.
REQ-033 Without RADIO_COLL_DET_EN: port tx_coll is absent and no collision is checked; the frame always completes.

Verification
REQ-034 BIT_CYCLES=4, idle wire, send 8'hA5 -> ant_oe high for 40 cycles; ant_o bit sequence 1,1,0,1,0,0,1,0,1,0; tx_busy low 48 cycles after transfer+CS.
REQ-035 Two instances on one wired-OR antenna; A sends 8'h3C -> B asserts rx_valid once with rx_data=8'h3C; A shows no rx_valid.
REQ-036 Hold ant_i high for 30 cycles, then issue a transfer -> no START until 4 clean low cycles have elapsed after ant_i falls.
REQ-037 Drive ant_i high through the whole stop bit of a peer frame -> rx_ferr pulses, rx_data holds its prior value, RX idles after ant_i falls.
REQ-038 Assert reset during DATA bit 3 -> ant_oe=0 immediately; after release, tx_ready=1 on the next edge and no rx_valid occurs.
REQ-039 With RADIO_COLL_DET_EN, force ant_i=1 during a 0 data bit -> tx_coll pulses once, ant_oe drops on the next cycle, and the GAP interval follows.
